// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input handshake, carry-chained add/subtract
// and a multi-cycle shift-add unsigned multiply.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_flush,
    input  logic [3:0]       i_opcode,
    input  logic [WIDTH-1:0] i_oper1,
    input  logic [WIDTH-1:0] i_oper2,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_res,
    output logic [WIDTH-1:0] o_res_hi,
    output logic [2:0]       o_status
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [3:0] OP_ZEROW = 4'd0;
    localparam logic [3:0] OP_BNOTW = 4'd1;
    localparam logic [3:0] OP_NEGTW = 4'd2;
    localparam logic [3:0] OP_INCRW = 4'd3;
    localparam logic [3:0] OP_DECRW = 4'd4;
    localparam logic [3:0] OP_ANDWP = 4'd5;
    localparam logic [3:0] OP_IORWP = 4'd6;
    localparam logic [3:0] OP_XORWP = 4'd7;
    localparam logic [3:0] OP_ADDWP = 4'd8;
    localparam logic [3:0] OP_SUBWP = 4'd9;
    localparam logic [3:0] OP_CMPWP = 4'd10;
    localparam logic [3:0] OP_SHFLW = 4'd11;
    localparam logic [3:0] OP_SHFRW = 4'd12;
    localparam logic [3:0] OP_ADCWP = 4'd13;
    localparam logic [3:0] OP_SBCWP = 4'd14;
    localparam logic [3:0] OP_MULWP = 4'd15;

    logic [0:0]         state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [2:0]         status_q, status_d;
    logic               valid_q, valid_d;

    logic [WIDTH-1:0]   sc_res;
    logic               sc_c;
    logic [WIDTH:0]     ext_a, ext_b, ext_cin, wide;
    logic [2*WIDTH-1:0] acc_step;

    assign ext_a   = {1'b0, i_oper1};
    assign ext_b   = {1'b0, i_oper2};
    // Carry-in is the C flag of the last completed op.
    assign ext_cin = {{WIDTH{1'b0}}, status_q[2]};

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        wide   = '0;
        case (i_opcode)
            OP_ZEROW: sc_res = '0;
            OP_BNOTW: sc_res = ~i_oper1;
            OP_NEGTW: sc_res = '0 - i_oper1;
            OP_INCRW: sc_res = i_oper1 + WIDTH'(1);
            OP_DECRW: sc_res = i_oper1 - WIDTH'(1);
            OP_ANDWP: sc_res = i_oper1 & i_oper2;
            OP_IORWP: sc_res = i_oper1 | i_oper2;
            OP_XORWP: sc_res = i_oper1 ^ i_oper2;
            OP_ADDWP: begin
                wide   = ext_a + ext_b;
                sc_res = wide[WIDTH-1:0];
                sc_c   = wide[WIDTH];
            end
            OP_SUBWP: begin
                wide   = ext_a - ext_b;
                sc_res = wide[WIDTH-1:0];
                sc_c   = wide[WIDTH];
            end
            OP_CMPWP: begin
                if ($signed(i_oper1) > $signed(i_oper2)) begin
                    sc_res = WIDTH'(1);
                end else if ($signed(i_oper1) < $signed(i_oper2)) begin
                    sc_res = '1;
                end else begin
                    sc_res = '0;
                end
            end
            OP_SHFLW: sc_res = (i_oper2 >= WIDTH'(WIDTH)) ? '0 : (i_oper1 << i_oper2);
            OP_SHFRW: sc_res = (i_oper2 >= WIDTH'(WIDTH)) ? '0 : (i_oper1 >> i_oper2);
            OP_ADCWP: begin
                wide   = ext_a + ext_b + ext_cin;
                sc_res = wide[WIDTH-1:0];
                sc_c   = wide[WIDTH];
            end
            OP_SBCWP: begin
                wide   = ext_a - ext_b - ext_cin;
                sc_res = wide[WIDTH-1:0];
                sc_c   = wide[WIDTH];
            end
            default: sc_res = '0;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        status_d = status_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (i_opcode == OP_MULWP) begin
                        state_d  = ST_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, i_oper1};
                        mplier_d = i_oper2;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        res_d    = sc_res;
                        res_hi_d = '0;
                        status_d = {sc_c, sc_res[WIDTH-1], (sc_res == '0)};
                        valid_d  = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (i_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = ST_IDLE;
                        res_d    = acc_step[WIDTH-1:0];
                        res_hi_d = acc_step[2*WIDTH-1:WIDTH];
                        status_d = {(acc_step[2*WIDTH-1:WIDTH] != '0), acc_step[WIDTH-1],
                                    (acc_step[WIDTH-1:0] == '0)};
                        valid_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            status_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            status_q <= status_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready  = (state_q == ST_IDLE);
    assign o_valid  = valid_q;
    assign o_res    = res_q;
    assign o_res_hi = res_hi_q;
    assign o_status = status_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;

    localparam logic [3:0] OP_NEGTW = 4'd2;
    localparam logic [3:0] OP_INCRW = 4'd3;
    localparam logic [3:0] OP_ANDWP = 4'd5;
    localparam logic [3:0] OP_ADDWP = 4'd8;
    localparam logic [3:0] OP_SUBWP = 4'd9;
    localparam logic [3:0] OP_CMPWP = 4'd10;
    localparam logic [3:0] OP_SHFRW = 4'd12;
    localparam logic [3:0] OP_ADCWP = 4'd13;
    localparam logic [3:0] OP_SBCWP = 4'd14;
    localparam logic [3:0] OP_MULWP = 4'd15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v8, fl8, rdy8, ov8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, r8, h8;
    logic [2:0]  s8;
    logic        v16, fl16, rdy16, ov16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, r16, h16;
    logic [2:0]  s16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(rdy8), .i_flush(fl8),
        .i_opcode(op8), .i_oper1(a8), .i_oper2(b8), .o_valid(ov8), .o_res(r8),
        .o_res_hi(h8), .o_status(s8)
    );

    alu_seq #(.WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v16), .o_ready(rdy16), .i_flush(fl16),
        .i_opcode(op16), .i_oper1(a16), .i_oper2(b16), .o_valid(ov16), .o_res(r16),
        .o_res_hi(h16), .o_status(s16)
    );

    // Issue one op and return 1ns after the accepting edge.
    task automatic op8_issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        v8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(posedge clk); #1;
        v8 = 1'b0;
    endtask

    task automatic op16_issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        v16 = 1'b1; op16 = op; a16 = a; b16 = b;
        @(posedge clk); #1;
        v16 = 1'b0;
    endtask

    task automatic test_reset;
        int pulses;
        #12;
        checks++;
        if ({r8, h8, s8, ov8, rdy8} !== {8'h00, 8'h00, 3'b000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset8 res/hi/st/v/rdy got %h/%h/%b/%b/%b want 00/00/000/0/1",
                     r8, h8, s8, ov8, rdy8);
        end
        checks++;
        if ({r16, h16, s16, ov16, rdy16} !== {16'h0, 16'h0, 3'b000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset16 res/hi/st/v/rdy got %h/%h/%b/%b/%b want 0/0/000/0/1",
                     r16, h16, s16, ov16, rdy16);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        op8_issue(OP_MULWP, 8'hFF, 8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({r8, s8, ov8, rdy8} !== {8'h00, 3'b000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_mul res/st/v/rdy got %h/%b/%b/%b want 00/000/0/1",
                     r8, s8, ov8, rdy8);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (ov8) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 0 || r8 !== 8'h00) begin
            errors++;
            $display("FAIL reset_no_valid pulses/res got %0d/%h want 0/00", pulses, r8);
        end
    endtask

    task automatic test_stream;
        v8 = 1'b1; op8 = OP_SUBWP; a8 = 8'd75; b8 = 8'd206;
        @(posedge clk); #1;
        checks++;
        if ({ov8, r8, h8, s8} !== {1'b1, 8'h7D, 8'h00, 3'b100}) begin
            errors++;
            $display("FAIL stream_sub v/res/hi/st got %b/%h/%h/%b want 1/7d/00/100",
                     ov8, r8, h8, s8);
        end
        op8 = OP_SBCWP; a8 = 8'd10; b8 = 8'd3;
        @(posedge clk); #1;
        checks++;
        if ({ov8, r8, s8} !== {1'b1, 8'h06, 3'b000}) begin
            errors++;
            $display("FAIL stream_sbc v/res/st got %b/%h/%b want 1/06/000", ov8, r8, s8);
        end
        op8 = OP_ADDWP; a8 = 8'd200; b8 = 8'd100;
        @(posedge clk); #1;
        v8 = 1'b0;
        checks++;
        if ({ov8, r8, s8} !== {1'b1, 8'h2C, 3'b100}) begin
            errors++;
            $display("FAIL stream_add v/res/st got %b/%h/%b want 1/2c/100", ov8, r8, s8);
        end
        @(posedge clk); #1;
        checks++;
        if (ov8 !== 1'b0 || r8 !== 8'h2C) begin
            errors++;
            $display("FAIL stream_idle v/res got %b/%h want 0/2c", ov8, r8);
        end
    endtask

    task automatic test_mul8;
        int low;
        bit got;
        low = 0; got = 1'b0;
        op8_issue(OP_MULWP, 8'hFF, 8'hFF);
        for (int i = 0; i < 20 && !got; i++) begin
            if (!rdy8) low++;
            if (ov8) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!got || low != 8) begin
            errors++;
            $display("FAIL mul8_timing got_valid/ready_low got %0d/%0d want 1/8", got, low);
        end
        checks++;
        if ({r8, h8, s8, rdy8} !== {8'h01, 8'hFE, 3'b100, 1'b1}) begin
            errors++;
            $display("FAIL mul8_result lo/hi/st/rdy got %h/%h/%b/%b want 01/fe/100/1",
                     r8, h8, s8, rdy8);
        end
        @(posedge clk); #1;
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL mul8_single_pulse v got %b want 0", ov8);
        end
    endtask

    task automatic test_busy_flush;
        int pulses;
        op8_issue(OP_ANDWP, 8'hF0, 8'h3C);
        checks++;
        if ({r8, h8, s8} !== {8'h30, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL and_pre res/hi/st got %h/%h/%b want 30/00/000", r8, h8, s8);
        end
        op8_issue(OP_MULWP, 8'd3, 8'd5);
        v8 = 1'b1; op8 = OP_ADDWP; a8 = 8'd1; b8 = 8'd1;
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (ov8 || rdy8) pulses++;
        end
        v8 = 1'b0;
        checks++;
        if (pulses != 0 || r8 !== 8'h30) begin
            errors++;
            $display("FAIL busy_ignore bad_cycles/res got %0d/%h want 0/30", pulses, r8);
        end
        fl8 = 1'b1;
        @(posedge clk); #1;
        fl8 = 1'b0;
        checks++;
        if ({rdy8, ov8, r8, s8} !== {1'b1, 1'b0, 8'h30, 3'b000}) begin
            errors++;
            $display("FAIL flush rdy/v/res/st got %b/%b/%h/%b want 1/0/30/000",
                     rdy8, ov8, r8, s8);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ov8) pulses++;
        end
        checks++;
        if (pulses != 0 || r8 !== 8'h30) begin
            errors++;
            $display("FAIL flush_quiet pulses/res got %0d/%h want 0/30", pulses, r8);
        end
    endtask

    task automatic test_edges;
        op8_issue(OP_NEGTW, 8'h80, 8'h00);
        checks++;
        if ({r8, s8} !== {8'h80, 3'b010}) begin
            errors++;
            $display("FAIL negtw_min res/st got %h/%b want 80/010", r8, s8);
        end
        op8_issue(OP_SHFRW, 8'hCC, 8'd9);
        checks++;
        if ({r8, s8} !== {8'h00, 3'b001}) begin
            errors++;
            $display("FAIL shfrw_over res/st got %h/%b want 00/001", r8, s8);
        end
        op8_issue(OP_SHFRW, 8'hCC, 8'd2);
        checks++;
        if ({r8, s8} !== {8'h33, 3'b000}) begin
            errors++;
            $display("FAIL shfrw_2 res/st got %h/%b want 33/000", r8, s8);
        end
        op8_issue(OP_CMPWP, 8'h80, 8'h01);
        checks++;
        if ({r8, s8} !== {8'hFF, 3'b010}) begin
            errors++;
            $display("FAIL cmpwp_lt res/st got %h/%b want ff/010", r8, s8);
        end
        op8_issue(OP_CMPWP, 8'h05, 8'hFE);
        checks++;
        if ({r8, s8} !== {8'h01, 3'b000}) begin
            errors++;
            $display("FAIL cmpwp_gt res/st got %h/%b want 01/000", r8, s8);
        end
        op8_issue(OP_INCRW, 8'hFF, 8'h00);
        checks++;
        if ({r8, s8} !== {8'h00, 3'b001}) begin
            errors++;
            $display("FAIL incrw_wrap res/st got %h/%b want 00/001", r8, s8);
        end
    endtask

    task automatic test_width16;
        int low;
        bit got;
        op16_issue(OP_ADDWP, 16'hFFFF, 16'h0001);
        checks++;
        if ({r16, s16} !== {16'h0000, 3'b101}) begin
            errors++;
            $display("FAIL w16_add res/st got %h/%b want 0000/101", r16, s16);
        end
        op16_issue(OP_ADCWP, 16'hFFFF, 16'h0000);
        checks++;
        if ({r16, s16} !== {16'h0000, 3'b101}) begin
            errors++;
            $display("FAIL w16_adc res/st got %h/%b want 0000/101", r16, s16);
        end
        low = 0; got = 1'b0;
        op16_issue(OP_MULWP, 16'd300, 16'd300);
        for (int i = 0; i < 40 && !got; i++) begin
            if (!rdy16) low++;
            if (ov16) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!got || low != 16) begin
            errors++;
            $display("FAIL w16_mul_timing got_valid/ready_low got %0d/%0d want 1/16", got, low);
        end
        checks++;
        if ({h16, r16, s16} !== {16'h0001, 16'h5F90, 3'b100}) begin
            errors++;
            $display("FAIL w16_mul hi/lo/st got %h/%h/%b want 0001/5f90/100", h16, r16, s16);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v8 = 1'b0; fl8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        v16 = 1'b0; fl16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        test_reset;
        test_stream;
        test_mul8;
        test_busy_flush;
        test_edges;
        test_width16;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
